adder_packer: RTL and testbench
===============================

ADDER_PACKER -- requirements
Module: adder_packer

Interface
REQ-001 SHALL have parameter BITS, default 16, width of one data word.
REQ-002 SHALL have parameter NUM, default 4, words per packed vector (NUM >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid  input  1  data_in holds a word this cycle.
REQ-006 SHALL have port data_in  input  BITS  incoming serial word.
REQ-007 SHALL have port last  input  1  close the current vector early, padding the rest with zeros.
REQ-008 SHALL have port clear  input  1  discard any partial vector.
REQ-009 SHALL have port valid_out  output  1  one-cycle pulse; data_out holds a new vector.
REQ-010 SHALL have port data_out  output  NUM*BITS  packed vector; word 0 in the MSBs, word NUM-1 in the LSBs.
REQ-011 SHALL have port partial_out  output  1  qualifies valid_out; the vector was zero-padded.
REQ-012 SHALL have port frames_out  output  16  count of emitted vectors, saturating.

Function
REQ-013 SHALL keep a slot index idx (0..NUM-1) and FSM states EMPTY (idx==0) and FILLING (idx>0).
REQ-014 On a valid cycle, SHALL write data_in into slot idx and increment idx.
REQ-015 When a valid word fills slot NUM-1, SHALL emit a full vector and set idx to 0, entering EMPTY.
REQ-016 When valid and last occur together, SHALL write the word, emit the vector with higher slots zeroed, and set idx to 0.
REQ-017 When last occurs without valid in FILLING, SHALL emit the padded partial vector; in EMPTY this is a no-op with no emission.
REQ-018 partial_out SHALL be 1 exactly when the emitted vector holds fewer than NUM received words.
REQ-019 Latency: valid_out SHALL assert on the cycle after the completing sample, for exactly one cycle.
REQ-020 data_out and partial_out SHALL hold their values until the next emission.
REQ-021 Back-to-back vectors SHALL be supported with no input bubble; a word arriving in the emission cycle goes to slot 0 of the next vector.
REQ-022 clear SHALL set idx to 0 and drop the partial contents without emitting.
REQ-023 clear SHALL override valid and last in the same cycle; that word is dropped.
REQ-024 A vector already scheduled for emission SHALL still be emitted.
REQ-025 frames_out SHALL increment on every valid_out and hold at 0xFFFF once it is reached.
REQ-026 The block SHALL never stall its input and SHALL have no ready signal.

Reset
REQ-027 Reset SHALL be asynchronous on negedge resetn.
REQ-028 During reset, SHALL hold valid_out=0, data_out=0, partial_out=0, frames_out=0, idx=0, state EMPTY, and all slots=0.
REQ-029 Reset mid-vector SHALL discard the partial vector; the first valid word after release SHALL land in slot 0.

Structure
REQ-030 SHALL place the BITS/NUM defaults and the state enum (EMPTY, FILLING) in shared package adder_pkg.
REQ-031 idx width SHALL be $clog2(NUM).
REQ-032 SHALL be a single module; no sub-module is natural.

Verification
REQ-033 Full vector: valid words 0x3c5f, 0xfda9, 0xe623, 0xf1ca on 4 consecutive cycles -> next cycle valid_out=1, data_out=64'h3c5ffda9e623f1ca, partial_out=0, frames_out=1.
REQ-034 Back-to-back: 8 consecutive valid words -> two single-cycle valid_out pulses 4 cycles apart, with correct word order.
REQ-035 Partial: 0xc25c, 0x6b7f with last on the second word -> data_out=64'hc25c6b7f00000000, partial_out=1.
REQ-036 Clear: 0x0e83, 0xc795, then clear, then 0xe409, 0x885c, 0x7520, 0x3457 -> single emission of 64'he409885c75203457.
REQ-037 Reset mid-vector: 2 words, then resetn low for 3 cycles, then 4 words -> outputs 0 during reset; one emission containing only the post-reset words.
REQ-038 Edge cases: last in EMPTY -> no valid_out; force 65536 emissions -> frames_out saturates at 0xFFFF.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and state type for the serial-to-parallel word packer.
package adder_pkg;

  localparam int BITS_DEF = 16;
  localparam int NUM_DEF  = 4;

  // EMPTY: no word collected yet (idx == 0); FILLING: idx > 0.
  typedef enum logic {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } state_t;

endpackage

// File: rtl/adder_packer.sv
// Packs a stream of BITS-wide words into NUM-word vectors. Word 0 lands in the
// MSBs. A vector is emitted when the last slot fills or when 'last' closes it
// early (zero-padded). 'clear' drops the partial vector. Never stalls input.
module adder_packer
  import adder_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int NUM  = NUM_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  input  logic [BITS-1:0]     data_in,
  input  logic                last,
  input  logic                clear,
  output logic                valid_out,
  output logic [NUM*BITS-1:0] data_out,
  output logic                partial_out,
  output logic [15:0]         frames_out
);

  localparam int IW = $clog2(NUM);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM - 1);

  logic [BITS-1:0]     slot_reg [NUM];
  logic [IW-1:0]       idx_reg;
  state_t              state_reg;

  logic [NUM*BITS-1:0] vec_next;
  logic                emit;
  logic                partial_next;

  // Vector as it would look if emitted now: stored slots below idx, the
  // incoming word at idx (when valid), zeros above. Stale slot contents from
  // earlier vectors are masked out here rather than being cleared.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_vec
    assign vec_next[(NUM-1-gi)*BITS +: BITS] =
      (IW'(gi) < idx_reg)                ? slot_reg[gi] :
      ((IW'(gi) == idx_reg) && valid)    ? data_in      : '0;
  end

  // Emission decision; clear wins over valid and last in the same cycle.
  always_comb begin
    emit         = 1'b0;
    partial_next = 1'b0;
    if (!clear) begin
      if (valid && (last || (idx_reg == IDX_LAST))) begin
        emit         = 1'b1;
        partial_next = (idx_reg != IDX_LAST);
      end else if (!valid && last && (state_reg == FILLING)) begin
        emit         = 1'b1;
        partial_next = 1'b1;
      end
    end
  end

  // Slot/idx FSM with registered outputs and saturating frame counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM; i++) slot_reg[i] <= '0;
      idx_reg     <= '0;
      state_reg   <= EMPTY;
      valid_out   <= 1'b0;
      data_out    <= '0;
      partial_out <= 1'b0;
      frames_out  <= '0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        data_out    <= vec_next;
        partial_out <= partial_next;
        if (frames_out != 16'hFFFF) frames_out <= frames_out + 16'd1;
      end

      if (clear || emit) begin
        idx_reg   <= '0;
        state_reg <= EMPTY;
      end else if (valid) begin
        slot_reg[idx_reg] <= data_in;
        idx_reg           <= idx_reg + IW'(1);
        state_reg         <= FILLING;
      end
    end
  end

endmodule

// File: tb/tb_adder_packer.sv
// Self-checking bench for adder_packer: queue-based reference model, one task
// per scenario, randomized words and control.
module tb_adder_packer;

  localparam int BITS = 16;
  localparam int NUM  = 4;
  localparam int VW   = NUM * BITS;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            valid = 1'b0;
  logic [BITS-1:0] data_in = '0;
  logic            last = 1'b0;
  logic            clear = 1'b0;
  logic            valid_out;
  logic [VW-1:0]   data_out;
  logic            partial_out;
  logic [15:0]     frames_out;

  adder_packer #(.BITS(BITS), .NUM(NUM)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .data_in(data_in),
    .last(last), .clear(clear), .valid_out(valid_out), .data_out(data_out),
    .partial_out(partial_out), .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [BITS-1:0] cur[$];
  logic            exp_valid = 1'b0;
  logic [VW-1:0]   exp_data = '0;
  logic            exp_partial = 1'b0;
  logic [15:0]     exp_frames = '0;

  // Drive one cycle of inputs, advance the model at the sampling edge,
  // then settle 1 time unit after the edge for checking.
  task automatic step(input logic v, input logic [BITS-1:0] d,
                      input logic l, input logic c);
    logic [VW-1:0] vt;
    valid = v; data_in = d; last = l; clear = c;
    @(posedge clk);
    exp_valid = 1'b0;
    if (c) begin
      cur.delete();
    end else begin
      if (v) cur.push_back(d);
      if (cur.size() == NUM || (l && cur.size() > 0)) begin
        vt = '0;
        for (int i = 0; i < cur.size(); i++) vt[(NUM-1-i)*BITS +: BITS] = cur[i];
        exp_valid   = 1'b1;
        exp_data    = vt;
        exp_partial = (cur.size() < NUM);
        if (exp_frames != 16'hFFFF) exp_frames = exp_frames + 16'd1;
        cur.delete();
      end
    end
    #1;
    valid = 1'b0; last = 1'b0; clear = 1'b0;
  endtask

  task automatic model_reset();
    cur.delete();
    exp_valid = 1'b0; exp_data = '0; exp_partial = 1'b0; exp_frames = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_cmp++; if (partial_out !== 1'b0) begin n_bad++; $display("FAIL reset_partial_out: got %b want 0", partial_out); end
    n_cmp++; if (frames_out !== 16'd0) begin n_bad++; $display("FAIL reset_frames_out: got %h want 0", frames_out); end
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    $display("test_reset done");
  endtask

  task automatic test_full_vector();
    logic [BITS-1:0] w [4];
    w[0] = 16'h3c5f; w[1] = 16'hfda9; w[2] = 16'he623; w[3] = 16'hf1ca;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i], 1'b0, 1'b0);
      if (i < 3) begin
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL full_early_valid word%0d: got %b want 0", i, valid_out); end
      end
    end
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL full_valid_out: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 64'h3c5ffda9e623f1ca) begin n_bad++; $display("FAIL full_data_out: got %h want 3c5ffda9e623f1ca", data_out); end
    n_cmp++; if (partial_out !== 1'b0) begin n_bad++; $display("FAIL full_partial_out: got %b want 0", partial_out); end
    n_cmp++; if (frames_out !== 16'd1) begin n_bad++; $display("FAIL full_frames_out: got %0d want 1", frames_out); end
    step(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL full_pulse_width: got %b want 0", valid_out); end
    n_cmp++; if (data_out !== 64'h3c5ffda9e623f1ca) begin n_bad++; $display("FAIL full_data_hold: got %h want 3c5ffda9e623f1ca", data_out); end
    $display("test_full_vector done: data_out=%h frames=%0d", data_out, frames_out);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first_pulse = -1;
    int second_pulse = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, BITS'($urandom), 1'b0, 1'b0);
      if (valid_out === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i; else second_pulse = i;
      end
      n_cmp++; if (valid_out !== exp_valid) begin n_bad++; $display("FAIL b2b_valid cyc%0d: got %b want %b", i, valid_out, exp_valid); end
      n_cmp++; if (data_out !== exp_data) begin n_bad++; $display("FAIL b2b_data cyc%0d: got %h want %h", i, data_out, exp_data); end
    end
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulse_count: got %0d want 2", pulses); end
    n_cmp++; if (second_pulse - first_pulse !== 4) begin n_bad++; $display("FAIL b2b_pulse_spacing: got %0d want 4", second_pulse - first_pulse); end
    $display("test_back_to_back done: pulses=%0d", pulses);
  endtask

  task automatic test_partial();
    step(1'b1, 16'hc25c, 1'b0, 1'b0);
    step(1'b1, 16'h6b7f, 1'b1, 1'b0);
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL partial_valid_out: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 64'hc25c6b7f00000000) begin n_bad++; $display("FAIL partial_data_out: got %h want c25c6b7f00000000", data_out); end
    n_cmp++; if (partial_out !== 1'b1) begin n_bad++; $display("FAIL partial_flag: got %b want 1", partial_out); end
    // last without valid while FILLING closes a 3-word vector
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (data_out !== 64'h1111222233330000 || partial_out !== 1'b1 || valid_out !== 1'b1)
      begin n_bad++; $display("FAIL partial_last_only: got %h/%b/%b want 1111222233330000/1/1", data_out, partial_out, valid_out); end
    $display("test_partial done: data_out=%h", data_out);
  endtask

  task automatic test_clear();
    int pulses = 0;
    step(1'b1, 16'h0e83, 1'b0, 1'b0);
    step(1'b1, 16'hc795, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    if (valid_out === 1'b1) pulses++;
    step(1'b1, 16'he409, 1'b0, 1'b0); if (valid_out === 1'b1) pulses++;
    step(1'b1, 16'h885c, 1'b0, 1'b0); if (valid_out === 1'b1) pulses++;
    step(1'b1, 16'h7520, 1'b0, 1'b0); if (valid_out === 1'b1) pulses++;
    step(1'b1, 16'h3457, 1'b0, 1'b0); if (valid_out === 1'b1) pulses++;
    n_cmp++; if (data_out !== 64'he409885c75203457) begin n_bad++; $display("FAIL clear_data_out: got %h want e409885c75203457", data_out); end
    step(1'b0, '0, 1'b0, 1'b0); if (valid_out === 1'b1) pulses++;
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL clear_emissions: got %0d want 1", pulses); end
    // clear overrides a completing valid+last word
    step(1'b1, 16'haaaa, 1'b0, 1'b0);
    step(1'b1, 16'hbbbb, 1'b1, 1'b1);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL clear_override: got %b want 0", valid_out); end
    // clear right after a completing sample: scheduled vector still emitted
    step(1'b1, 16'hcccc, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (data_out !== 64'hcccc000000000000) begin n_bad++; $display("FAIL clear_after_emit: got %h want cccc000000000000", data_out); end
    $display("test_clear done: pulses=%0d", pulses);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    step(1'b1, BITS'($urandom), 1'b0, 1'b0);
    step(1'b1, BITS'($urandom), 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (valid_out !== 1'b0 || data_out !== '0 || partial_out !== 1'b0 || frames_out !== 16'd0)
        begin n_bad++; $display("FAIL resetmid_outputs cyc%0d: got %b/%h/%b/%h want all 0", i, valid_out, data_out, partial_out, frames_out); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, BITS'($urandom), 1'b0, 1'b0);
      if (valid_out === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL resetmid_emissions: got %0d want 1", pulses); end
    n_cmp++; if (data_out !== exp_data || partial_out !== 1'b0) begin n_bad++; $display("FAIL resetmid_data: got %h/%b want %h/0", data_out, partial_out, exp_data); end
    n_cmp++; if (frames_out !== 16'd1) begin n_bad++; $display("FAIL resetmid_frames: got %0d want 1", frames_out); end
    $display("test_reset_mid done: data_out=%h", data_out);
  endtask

  task automatic test_last_empty();
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL last_empty_valid: got %b want 0", valid_out); end
    n_cmp++; if (frames_out !== exp_frames) begin n_bad++; $display("FAIL last_empty_frames: got %0d want %0d", frames_out, exp_frames); end
    $display("test_last_empty done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), BITS'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
      n_cmp++;
      if (valid_out !== exp_valid || data_out !== exp_data ||
          partial_out !== exp_partial || frames_out !== exp_frames) begin
        n_bad++;
        $display("FAIL random cyc%0d: got v=%b d=%h p=%b f=%0d want v=%b d=%h p=%b f=%0d", i,
                 valid_out, data_out, partial_out, frames_out, exp_valid, exp_data, exp_partial, exp_frames);
      end
    end
    $display("test_random done: frames=%0d", frames_out);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 65540; i++) step(1'b1, BITS'($urandom), 1'b1, 1'b0);
    n_cmp++; if (frames_out !== exp_frames) begin n_bad++; $display("FAIL sat_model: got %h want %h", frames_out, exp_frames); end
    n_cmp++; if (frames_out !== 16'hFFFF) begin n_bad++; $display("FAIL sat_frames: got %h want ffff", frames_out); end
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 1'b1, 1'b0);
    n_cmp++; if (frames_out !== 16'hFFFF || valid_out !== 1'b1) begin n_bad++; $display("FAIL sat_hold: got %h/%b want ffff/1", frames_out, valid_out); end
    n_cmp++; if (data_out !== 64'h1234567800000000) begin n_bad++; $display("FAIL sat_data: got %h want 1234567800000000", data_out); end
    $display("test_saturate done: frames=%h", frames_out);
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_back_to_back();
    test_partial();
    test_clear();
    test_reset_mid();
    test_last_empty();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
